// File: rtl/config_register_file.sv
// Configuration register file: NUM_RW read-write registers followed by NUM_RO
// read-only status words, mapped at BASE_ADDR with one word every DATA_BITS/8 bytes.
// Writes are fire-and-forget strobes. Reads use a valid/ready request and a
// registered valid/ready response that can sustain one read per cycle.
//
// Read FSM
//   state | meaning
//   IDLE  | no response pending; requests always accepted
//   RESP  | response held on resp_*; new request accepted only with resp_ready
module config_register_file #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          NUM_RW    = 8,
    parameter int          NUM_RO    = 4,
    parameter int          ADDR_BITS = 32,
    parameter int          DATA_BITS = 32,
    localparam int         RO_BITS   = ((NUM_RO > 0) ? NUM_RO : 1) * DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_BITS-1:0]        wr_addr,
    input  logic [DATA_BITS-1:0]        wr_data,
    input  logic                        wr_valid,
    input  logic [ADDR_BITS-1:0]        rd_addr,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    output logic [DATA_BITS-1:0]        resp_data,
    output logic                        resp_error,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    input  logic [RO_BITS-1:0]          ro_data,
    output logic [NUM_RW*DATA_BITS-1:0] regs,
    output logic [NUM_RW-1:0]           wr_pulse
);

    localparam int STRIDE  = DATA_BITS / 8;
    localparam int OFF_LSB = $clog2(STRIDE);

    localparam logic [ADDR_BITS-1:0] BASE       = ADDR_BITS'(BASE_ADDR);
    localparam logic [ADDR_BITS-1:0] NUM_RW_A   = ADDR_BITS'(NUM_RW);
    localparam logic [ADDR_BITS-1:0] NUM_REGS_A = ADDR_BITS'(NUM_RW + NUM_RO);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [DATA_BITS-1:0] reg_q [NUM_RW];
    logic [0:0]           state_q;

    logic [ADDR_BITS-1:0] wr_idx;
    logic                 wr_hit;
    logic [ADDR_BITS-1:0] rd_idx;
    logic                 rd_ok;
    logic [DATA_BITS-1:0] rd_word;
    logic                 rd_accept;

    // Addresses below BASE wrap to a huge offset and fall out of range.
    function automatic logic [ADDR_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr);
        logic [ADDR_BITS-1:0] off;
        off = addr - BASE;
        return off >> OFF_LSB;
    endfunction

    function automatic logic addr_ok(input logic [ADDR_BITS-1:0] addr);
        logic [ADDR_BITS-1:0] off;
        off = addr - BASE;
        return (off[OFF_LSB-1:0] == '0) && ((off >> OFF_LSB) < NUM_REGS_A);
    endfunction

    // Write decode: only aligned, in-range RW indices land.
    always_comb begin
        wr_idx = addr_index(wr_addr);
        wr_hit = wr_valid && addr_ok(wr_addr) && (wr_idx < NUM_RW_A);
    end

    // RW register storage and one-cycle write strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RW; i++) reg_q[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_hit && (wr_idx == ADDR_BITS'(i))) begin
                    reg_q[i]    <= wr_data;
                    wr_pulse[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_pack
        assign regs[g*DATA_BITS +: DATA_BITS] = reg_q[g];
    end

    // Read mux: sees pre-write register contents, so a same-edge write is not visible.
    always_comb begin
        rd_idx  = addr_index(rd_addr);
        rd_ok   = addr_ok(rd_addr);
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rd_idx == ADDR_BITS'(i)) rd_word = reg_q[i];
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (rd_idx == ADDR_BITS'(NUM_RW + i)) rd_word = ro_data[i*DATA_BITS +: DATA_BITS];
        end
        if (!rd_ok) rd_word = '0;
    end

    assign rd_ready   = (state_q == IDLE) || resp_ready;
    assign rd_accept  = rd_valid && rd_ready;
    assign resp_valid = (state_q == RESP);

    // Read response FSM: load on accept, drain to IDLE when consumed without a follow-on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            resp_data  <= '0;
            resp_error <= 1'b0;
        end else if (rd_accept) begin
            state_q    <= RESP;
            resp_data  <= rd_word;
            resp_error <= !rd_ok;
        end else if (resp_ready) begin
            state_q    <= IDLE;
        end
    end

endmodule

// File: tb/tb_config_register_file.sv
// Bench for config_register_file: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the register map.
module tb_config_register_file;

    localparam logic [31:0] BASE = 32'h1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  wr_addr;
    logic [63:0]  wr_data;
    logic         wr_valid;
    logic [31:0]  rd_addr;
    logic         rd_valid;
    logic         rd_ready;
    logic [63:0]  resp_data;
    logic         resp_error;
    logic         resp_valid;
    logic         resp_ready;
    logic [255:0] ro_data;
    logic [511:0] regs;
    logic [7:0]   wr_pulse;

    config_register_file #(
        .BASE_ADDR (64'h1000),
        .NUM_RW    (8),
        .NUM_RO    (4),
        .ADDR_BITS (32),
        .DATA_BITS (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .resp_data  (resp_data),
        .resp_error (resp_error),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .ro_data    (ro_data),
        .regs       (regs),
        .wr_pulse   (wr_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [63:0] m_regs [8];
    logic [63:0] m_ro   [4];
    bit          m_busy;
    logic [63:0] m_data;
    bit          m_err;
    logic [7:0]  m_pulse;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] addr, output bit ok, output int idx);
        logic [31:0] off;
        off = addr - BASE;
        ok  = (off % 8 == 0) && (off / 8 < 12);
        idx = ok ? int'(off / 8) : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_busy = 0; m_data = '0; m_err = 0; m_pulse = '0;
    endtask

    task automatic model_edge();
        bit ok;
        int idx;
        if (rd_valid && (!m_busy || resp_ready)) begin
            ref_decode(rd_addr, ok, idx);
            m_busy = 1;
            m_err  = !ok;
            m_data = !ok ? 64'h0 : (idx < 8) ? m_regs[idx] : m_ro[idx-8];
        end else if (m_busy && resp_ready) begin
            m_busy = 0;
        end
        m_pulse = '0;
        ref_decode(wr_addr, ok, idx);
        if (wr_valid && ok && idx < 8) begin
            m_regs[idx] = wr_data;
            m_pulse     = 8'(1 << idx);
        end
    endtask

    task automatic check_outputs();
        chk("resp_valid", 64'(resp_valid), 64'(m_busy));
        if (m_busy) begin
            chk("resp_data", resp_data, m_data);
            chk("resp_error", 64'(resp_error), 64'(m_err));
        end
        chk("wr_pulse", 64'(wr_pulse), 64'(m_pulse));
        for (int i = 0; i < 8; i++) chk($sformatf("regs[%0d]", i), regs[i*64 +: 64], m_regs[i]);
    endtask

    task automatic set_ro();
        for (int i = 0; i < 4; i++) ro_data[i*64 +: 64] = m_ro[i];
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        #1;
        chk("rd_ready", 64'(rd_ready), 64'(!m_busy || resp_ready));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        rd_valid = 0; rd_addr = '0; resp_ready = 1;
    endtask

    task automatic write(input logic [31:0] a, input logic [63:0] d);
        idle_inputs();
        wr_valid = 1; wr_addr = a; wr_data = d;
        step();
    endtask

    task automatic read(input logic [31:0] a);
        idle_inputs();
        rd_valid = 1; rd_addr = a;
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return BASE + 32'($urandom_range(0, 15)) * 8 + 32'($urandom_range(1, 7));
            1:       return BASE - 32'($urandom_range(1, 64)) * 8;
            2:       return BASE + 32'($urandom_range(12, 40)) * 8;
            default: return BASE + 32'($urandom_range(0, 11)) * 8;
        endcase
    endfunction

    initial begin
        idle_inputs();
        for (int i = 0; i < 4; i++) m_ro[i] = '0;
        m_ro[1] = 64'h55;
        set_ro();
        model_reset();
        rst_n = 0;
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_error", 64'(resp_error), 64'h0);
        chk("rst_resp_data", resp_data, 64'h0);
        chk("rst_rd_ready", 64'(rd_ready), 64'h1);
        chk("rst_wr_pulse", 64'(wr_pulse), 64'h0);
        chk("rst_regs_lo", regs[63:0], 64'h0);
        chk("rst_regs_hi", regs[511:448], 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        step();

        // write + pulse + read back
        write(32'h1010, 64'hDEAD);
        chk("dead_pulse", 64'(wr_pulse), 64'h04);
        chk("dead_reg2", regs[2*64 +: 64], 64'hDEAD);
        idle_inputs(); step();
        chk("dead_pulse_clr", 64'(wr_pulse), 64'h0);
        read(32'h1010);
        chk("dead_rd_valid", 64'(resp_valid), 64'h1);
        chk("dead_rd_data", resp_data, 64'hDEAD);
        chk("dead_rd_err", 64'(resp_error), 64'h0);

        // read-only entry and dropped write to it
        read(32'h1048);
        chk("ro1_data", resp_data, 64'h55);
        chk("ro1_err", 64'(resp_error), 64'h0);
        write(32'h1048, 64'hFFFF_0000_1234_5678);
        chk("ro_wr_pulse", 64'(wr_pulse), 64'h0);
        chk("ro_wr_reg2", regs[2*64 +: 64], 64'hDEAD);

        // invalid addresses
        read(32'h1004);
        chk("misalign_err", 64'(resp_error), 64'h1);
        chk("misalign_data", resp_data, 64'h0);
        read(32'h1060);
        chk("oor_err", 64'(resp_error), 64'h1);
        read(32'h0FF8);
        chk("below_err", 64'(resp_error), 64'h1);
        chk("below_data", resp_data, 64'h0);
        write(32'h1004, 64'h1); write(32'h0FF8, 64'h2); write(32'h1060, 64'h3);

        // back-to-back writes, last wins
        write(32'h1000, 64'h3);
        write(32'h1008, 64'h11);
        write(32'h1008, 64'h22);
        chk("b2b_reg1", regs[64 +: 64], 64'h22);

        // stall with pending response, then four queued reads
        read(32'h1010);
        resp_ready = 0; rd_valid = 1; rd_addr = BASE;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_data", resp_data, 64'hDEAD);
            chk("stall_rd_ready", 64'(rd_ready), 64'h0);
        end
        for (int i = 0; i < 4; i++) begin
            resp_ready = 1; rd_valid = 1; rd_addr = BASE + 32'(i) * 8;
            step();
            chk("burst_valid", 64'(resp_valid), 64'h1);
        end
        chk("burst_last", resp_data, 64'h0);
        idle_inputs(); step();

        // same-edge read and write collision
        idle_inputs();
        wr_valid = 1; wr_addr = BASE; wr_data = 64'h7;
        rd_valid = 1; rd_addr = BASE;
        step();
        chk("collide_old", resp_data, 64'h3);
        read(BASE);
        chk("collide_new", resp_data, 64'h7);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            wr_valid   = ($urandom_range(0, 2) != 0);
            wr_addr    = rand_addr();
            wr_data    = {$urandom, $urandom};
            rd_valid   = ($urandom_range(0, 3) != 0);
            rd_addr    = rand_addr();
            resp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) m_ro[$urandom_range(0, 3)] = {$urandom, $urandom};
            set_ro();
            step();
        end

        // async reset while a response is pending
        idle_inputs();
        rd_valid = 1; rd_addr = 32'h1010; resp_ready = 0;
        step();
        chk("pre_rst_valid", 64'(resp_valid), 64'h1);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("arst_resp_valid", 64'(resp_valid), 64'h0);
        chk("arst_rd_ready", 64'(rd_ready), 64'h1);
        chk("arst_regs2", regs[2*64 +: 64], 64'h0);
        chk("arst_regs_all", 64'(|regs), 64'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        wr_valid = 1; wr_addr = 32'h1018; wr_data = 64'hABCD;
        step();
        chk("post_rst_wr", regs[3*64 +: 64], 64'hABCD);
        chk("post_rst_pulse", 64'(wr_pulse), 64'h08);
        idle_inputs(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
